// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// dmem_arbiter
//
// Shares one single-port data memory (asynchronous read, synchronous write)
// between the pipeline MEM stage (port A) and a secondary master such as a
// loader or debug port (port B). At most one access is granted per cycle.
// Reads return through a registered one-cycle response per port.
//
// Optional feature macro: DMARB_STARVE_GUARD_EN
//   When defined, a saturating starvation counter forces a grant to port B
//   after STARVE_LIMIT contended cycles in which B lost. When undefined, port A
//   has pure fixed priority and no counter is built.
//
// Ports:
//   clk, rst                 rising-edge clock, async active-high reset
//   a_req/a_we/a_addr/a_wdata  port A request, write enable, address, data
//   a_gnt, a_stall           port A grant (comb) and pipeline stall (comb)
//   a_rvalid, a_rdata        port A registered read response
//   b_*                      same set for port B (no stall output)
//   mem_we/mem_addr/mem_wdata  memory write strobe, address, write data
//   mem_rdata                memory asynchronous read data
//
// Handshake: a requester raises req with we/addr/wdata and holds all of them
// stable until it sees gnt high in the same cycle. The access is consumed at
// the rising edge ending a cycle with req & gnt; a cycle with req high and gnt
// low consumes nothing. A granted read answers with rvalid high for exactly
// the following cycle; rdata holds its last value whenever rvalid is low.
module dmem_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_stall,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // High when port B must win a contended cycle.
  logic force_b;

`ifdef DMARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;

  // Counts cycles where B waited; saturates at the limit and clears on any
  // B grant, so the forced grant itself resets the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (b_gnt) begin
      starve_cnt <= '0;
    end else if (b_req && (starve_cnt != LIMIT_C)) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  assign force_b = (starve_cnt == LIMIT_C);
`else
  localparam int unused_starve_limit = STARVE_LIMIT;
  assign force_b = 1'b0;
`endif

  // Grant: a lone requester wins; on contention A wins unless B is forced.
  // Reset blocks all grants so nothing is written or read while rst is high.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (!rst) begin
      if (a_req && !(b_req && force_b)) begin
        a_gnt = 1'b1;
      end else if (b_req) begin
        b_gnt = 1'b1;
      end
    end
  end

  assign a_stall = a_req & ~a_gnt;

  // Memory side follows the granted port, defaulting to A when idle.
  assign mem_addr  = b_gnt ? b_addr  : a_addr;
  assign mem_wdata = b_gnt ? b_wdata : a_wdata;
  assign mem_we    = (a_gnt & a_we) | (b_gnt & b_we);

  // Read responses: memory read data is sampled at the edge ending the grant
  // cycle. A write granted in the previous cycle has already landed, so
  // back-to-back write/read to one address sees the new data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rvalid <= 1'b0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= a_gnt & ~a_we;
      b_rvalid <= b_gnt & ~b_we;
      if (a_gnt && !a_we) begin
        a_rdata <= mem_rdata;
      end
      if (b_gnt && !b_we) begin
        b_rdata <= mem_rdata;
      end
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter sharing the single-port data memory (256 x 32-bit, word-addressed, asynchronous read, synchronous write) between the pipeline MEM stage (port A) and a secondary master such as a program/data loader or debug port (port B). It sits between both requesters and the data memory. It grants at most one access per cycle, drives the memory write strobe, address and write data, and returns read data to the winning requester through a registered one-cycle response. It also provides a stall signal for the pipeline.

## Interface
- `ADDR_W`, 8, word-address width; memory depth is 2^ADDR_W.
- `DATA_W`, 32, data width.
- `STARVE_LIMIT`, 4, number of contended cycles port B may lose before it is forced a grant (used only with the macro).

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `a_req`  in  1  port A access request; held until granted.
- `a_we`  in  1  port A write (1) / read (0).
- `a_addr`  in  ADDR_W  port A word address.
- `a_wdata`  in  DATA_W  port A write data.
- `a_gnt`  out  1  port A granted this cycle (combinational).
- `a_stall`  out  1  `a_req & ~a_gnt`, drives pipeline stall.
- `a_rvalid`  out  1  port A read data valid (registered).
- `a_rdata`  out  DATA_W  port A read data (registered).
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_gnt`, `b_rvalid`, `b_rdata`: same as the port A signals, for port B.
- `mem_we`  out  1  memory write strobe.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory asynchronous read data.

## Operation
- Grant rule: a lone requester wins. If both request, A wins, except under the starvation guard.
- Grant signals are one-hot or zero, and never both high.
- Memory mux: `mem_addr`/`mem_wdata` follow the granted port, and follow A when idle.
- `mem_we` = granted port's `we` & gnt. It is 0 when no port is granted.
- Granted write: the memory captures data at the same rising edge. There is no response, and `rvalid` stays 0.
- Granted read: `mem_rdata` is sampled at the rising edge into the port's `rdata` register, and `rvalid` = 1 for exactly the following cycle.
- `rdata` holds its last value when `rvalid` = 0.
- Back-to-back grants to the same port produce back-to-back `rvalid` pulses. The pipeline is fully pipelined at one access per cycle.
- Read-after-write to the same address on consecutive cycles returns the new data, because the write completes at the edge before the read samples.
- Requester rule: `we`/`addr`/`wdata` must be stable while `req` is high and ungranted. A request with `gnt` low is not consumed.
- Reset (asynchronous, any time):
  - `a_rvalid`, `b_rvalid` = 0; `a_rdata`, `b_rdata` = 0; starvation counter = 0.
  - While `rst` is high, `a_gnt`, `b_gnt`, `mem_we` are forced to 0 and `a_stall` = `a_req`.
  - A read in flight when `rst` rises is dropped; no `rvalid` follows.

## Timing
- Grant latency: 0 cycles (same cycle as `req`).
- Write latency: committed at the first rising edge with `gnt` high.
- Read latency: `rvalid`/`rdata` appear 1 cycle after the grant cycle.
- Throughput: one access per cycle total, across both ports.
- `rst` deassertion: arbitration resumes on the first cycle `rst` is low.

## Configuration
- `DMARB_STARVE_GUARD_EN` defined:
  - A saturating counter (width clog2(STARVE_LIMIT+1)) increments each cycle `b_req & ~b_gnt`, and clears on any `b_gnt`.
  - When the counter equals `STARVE_LIMIT`, a contended cycle grants B (A stalls). The counter then clears.
  - Uncontended cycles follow the normal rule.
- Not defined: pure fixed priority to A. No counter is built. B can starve indefinitely under continuous A traffic.

## Test plan
- Reset: assert `rst` mid-cycle with both `req` high → `a_gnt` = `b_gnt` = `mem_we` = 0 immediately; `rvalid` = 0, `rdata` = 0.
- Single port: A writes 0xDEADBEEF @ 0x10, then reads 0x10 the next cycle → `a_rvalid` = 1 one cycle later, `a_rdata` = 0xDEADBEEF; `b_rvalid` stays 0.
- Contention, guard off: A and B request continuously for 10 cycles → `a_gnt` = 1 every cycle, `b_gnt` = 0, `a_stall` = 0.
- Contention, guard on, `STARVE_LIMIT` = 4: same stimulus → `b_gnt` = 1 on cycles 5 and 10; `a_stall` = 1 on exactly those cycles; B read `rvalid` pulses on cycles 6 and 11.
- Cross-port coherence: B writes 0x0000_1234 @ 0x00, then A reads 0x00 the next cycle → `a_rdata` = 0x0000_1234.
- Reset mid-read: A read granted, `rst` raised before the next edge → no `a_rvalid` pulse after `rst` falls.
